// File: rtl/exc_commit_ctrl.sv
// Commit sequencer between WB and the CSR file: exceptions, interrupts, ertn and
// CSR writes, owning the CSR write port and the refetch redirect toward pre-IF.
module exc_commit_ctrl #(
  parameter bit FLUSH_ON_CSRWR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [4:0]  wb_exc_vec,
  input  logic        wb_is_ertn,
  input  logic        wb_csr_we,
  input  logic [13:0] wb_csr_num,
  input  logic [31:0] wb_csr_wmask,
  input  logic [31:0] wb_csr_wvalue,
  input  logic        has_int,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_entry,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] ex_pc,
  output logic        ertn_flush,
  output logic        pipe_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
);

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_target;
  logic [31:0] w_target_nxt;

  logic        w_take;
  logic        w_is_int;
  logic        w_is_exc;
  logic        w_is_ertn;
  logic        w_is_csrw;
  logic        w_refetch_csr;
  logic [5:0]  w_exc_ecode;

  // Lowest set exception bit wins.
  always_comb begin
    w_exc_ecode = ECODE_INT;
    if (wb_exc_vec[0])      w_exc_ecode = ECODE_ADEF;
    else if (wb_exc_vec[1]) w_exc_ecode = ECODE_INE;
    else if (wb_exc_vec[2]) w_exc_ecode = ECODE_SYS;
    else if (wb_exc_vec[3]) w_exc_ecode = ECODE_BRK;
    else if (wb_exc_vec[4]) w_exc_ecode = ECODE_ALE;
  end

  // CSRs whose update changes fetch/translation behaviour for younger instructions.
  always_comb begin
    w_refetch_csr = 1'b0;
    case (wb_csr_num)
      14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h00C: w_refetch_csr = 1'b1;
      default:                                              w_refetch_csr = 1'b0;
    endcase
  end

  assign w_take    = !reset && (r_state == ST_IDLE) && wb_valid;
  assign w_is_int  = w_take && has_int;
  assign w_is_exc  = w_take && !has_int && (|wb_exc_vec);
  assign w_is_ertn = w_take && !has_int && !(|wb_exc_vec) && wb_is_ertn;
  assign w_is_csrw = w_take && !has_int && !(|wb_exc_vec) && !wb_is_ertn && wb_csr_we;

  always_comb begin
    w_state_nxt    = r_state;
    w_target_nxt   = r_target;
    csr_we         = 1'b0;
    csr_num        = '0;
    csr_wmask      = '0;
    csr_wvalue     = '0;
    wb_ex          = 1'b0;
    wb_ecode       = '0;
    wb_esubcode    = '0;
    ex_pc          = '0;
    ertn_flush     = 1'b0;
    pipe_flush     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    busy           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_is_int || w_is_exc) begin
          wb_ex        = 1'b1;
          wb_ecode     = w_is_int ? ECODE_INT : w_exc_ecode;
          ex_pc        = wb_pc;
          pipe_flush   = 1'b1;
          w_target_nxt = ex_entry;
          w_state_nxt  = ST_REDIR;
        end else if (w_is_ertn) begin
          ertn_flush   = 1'b1;
          pipe_flush   = 1'b1;
          w_target_nxt = ertn_entry;
          w_state_nxt  = ST_REDIR;
        end else if (w_is_csrw) begin
          csr_we     = 1'b1;
          csr_num    = wb_csr_num;
          csr_wmask  = wb_csr_wmask;
          csr_wvalue = wb_csr_wvalue;
          if (FLUSH_ON_CSRWR && w_refetch_csr) begin
            pipe_flush   = 1'b1;
            w_target_nxt = wb_pc + 32'd4;
            w_state_nxt  = ST_REDIR;
          end
        end
      end
      ST_REDIR: begin
        // Redirect handshake: the target is held until pre-IF takes it.
        if (!reset) begin
          redirect_valid = 1'b1;
          redirect_pc    = r_target;
          busy           = 1'b1;
          if (redirect_ready) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_target <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_target <= w_target_nxt;
    end
  end

  a_commit_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(wb_ex && ertn_flush));

  a_flush_single: assert property (@(posedge clk) disable iff (reset)
    pipe_flush |=> !pipe_flush);

endmodule
